// File: rtl/scratchpad_window_ctrl.sv
// Scratchpad fill/replay sequencer: loads a word stream, then replays it as sliding windows.
// Optional stall counter output enabled by defining SCRATCHPAD_STALL_CNT_EN.
module scratchpad_window_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   cfg_len,
    input  logic [ADDR_WIDTH:0]   cfg_win,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    output logic                  cfg_err,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  sp_wen,
    output logic [ADDR_WIDTH-1:0] sp_waddr,
    output logic [DATA_WIDTH-1:0] sp_din,
    output logic [ADDR_WIDTH-1:0] sp_raddr,
    input  logic [DATA_WIDTH-1:0] sp_dout,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  out_final
`ifdef SCRATCHPAD_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int unsigned LEN_W = ADDR_WIDTH + 1;
    localparam int unsigned CMP_W = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_READ = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      win_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] off;

    logic                  cfg_bad_c;
    logic                  start_ok_c;
    logic                  fill_last_c;
    logic                  last_c;
    logic                  final_c;

    // Configuration legality and per-cycle decode
    always_comb begin
        cfg_bad_c = (cfg_len == '0)
                 || (cfg_len > LEN_W'(DEPTH))
                 || (cfg_win == '0)
                 || (cfg_win > cfg_len)
                 || (cfg_stride == '0);
        start_ok_c  = (state == S_IDLE) && start && !cfg_bad_c;
        fill_last_c = in_valid && ({1'b0, wptr} == (len_q - LEN_W'(1)));
        last_c      = ({1'b0, off} == (win_q - LEN_W'(1)));
        // Extra headroom bit keeps base+stride+win from overflowing
        final_c     = last_c && ((CMP_W'(base) + CMP_W'(stride_q) + CMP_W'(win_q)) > CMP_W'(len_q));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_ok_c) begin
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (fill_last_c) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (out_ready && final_c) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from state and the window counters
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        in_ready  = 1'b0;
        sp_wen    = 1'b0;
        sp_waddr  = '0;
        sp_raddr  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_final = 1'b0;
        case (state)
            S_FILL: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                sp_wen   = in_valid;
                sp_waddr = wptr;
            end
            S_READ: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                sp_raddr  = base + off;
                out_last  = last_c;
                out_final = final_c;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign sp_din   = in_data;
    assign out_data = sp_dout;

    // Config latch, write pointer and window base/offset counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            win_q    <= '0;
            stride_q <= '0;
            wptr     <= '0;
            base     <= '0;
            off      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok_c) begin
                        len_q    <= cfg_len;
                        win_q    <= cfg_win;
                        stride_q <= cfg_stride;
                        wptr     <= '0;
                        base     <= '0;
                        off      <= '0;
                    end
                end
                S_FILL: begin
                    if (in_valid) begin
                        wptr <= wptr + ADDR_WIDTH'(1);
                    end
                    if (fill_last_c) begin
                        base <= '0;
                        off  <= '0;
                    end
                end
                S_READ: begin
                    if (out_ready) begin
                        if (!last_c) begin
                            off <= off + ADDR_WIDTH'(1);
                        end else if (!final_c) begin
                            base <= base + stride_q;
                            off  <= '0;
                        end
                    end
                end
                default: begin
                    wptr <= wptr;
                end
            endcase
        end
    end

    // Rejected start reported one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= (state == S_IDLE) && start && cfg_bad_c;
        end
    end

`ifdef SCRATCHPAD_STALL_CNT_EN
    // Back-pressure cycles seen by the output stream, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (start_ok_c) begin
            stall_cnt <= '0;
        end else if ((state == S_READ) && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_scratchpad_window_ctrl.sv
// Directed bench for scratchpad_window_ctrl with a behavioural combinational-read scratchpad.
module tb_scratchpad_window_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   cfg_len;
    logic [AW:0]   cfg_win;
    logic [AW-1:0] cfg_stride;
    logic          cfg_err;
    logic          busy;
    logic          done;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          sp_wen;
    logic [AW-1:0] sp_waddr;
    logic [DW-1:0] sp_din;
    logic [AW-1:0] sp_raddr;
    logic [DW-1:0] sp_dout;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          out_final;
`ifdef SCRATCHPAD_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    int q_addr[$];
    int q_data[$];
    bit q_last[$];
    bit q_final[$];

    logic [DW-1:0] mem [DEPTH];

    scratchpad_window_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_len   (cfg_len),
        .cfg_win   (cfg_win),
        .cfg_stride(cfg_stride),
        .cfg_err   (cfg_err),
        .busy      (busy),
        .done      (done),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sp_wen    (sp_wen),
        .sp_waddr  (sp_waddr),
        .sp_din    (sp_din),
        .sp_raddr  (sp_raddr),
        .sp_dout   (sp_dout),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_final (out_final)
`ifdef SCRATCHPAD_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (sp_wen) begin
            mem[sp_waddr] <= sp_din;
        end
    end
    assign sp_dout = mem[sp_raddr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int a, input int d, input bit l, input bit f);
        q_addr.push_back(a);
        q_data.push_back(d);
        q_last.push_back(l);
        q_final.push_back(f);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_done"},      done, 0);
        check({tag, "_cfg_err"},   cfg_err, 0);
        check({tag, "_in_ready"},  in_ready, 0);
        check({tag, "_sp_wen"},    sp_wen, 0);
        check({tag, "_sp_waddr"},  sp_waddr, 0);
        check({tag, "_sp_raddr"},  sp_raddr, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"},  out_last, 0);
        check({tag, "_out_final"}, out_final, 0);
    endtask

    task automatic do_start(input int len, input int win, input int stride);
        cfg_len    = (AW+1)'(len);
        cfg_win    = (AW+1)'(win);
        cfg_stride = AW'(stride);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic bad_start(input string tag, input int len, input int win, input int stride);
        in_valid = 1'b1;
        #1;
        check({tag, "_idle_wen"}, sp_wen, 0);
        do_start(len, win, stride);
        #1;
        check({tag, "_cfg_err"},  cfg_err, 1);
        check({tag, "_busy"},     busy, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        @(negedge clk);
        #1;
        check({tag, "_cfg_err_clr"}, cfg_err, 0);
        check({tag, "_busy2"},       busy, 0);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic fill(input int n, input int base_val, input bit toggle);
        int writes = 0;
        int cyc    = 0;
        while (writes < n && cyc < 100) begin
            in_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            in_data  = DW'(base_val + writes);
            #1;
            check("fill_in_ready",  in_ready, 1);
            check("fill_busy",      busy, 1);
            check("fill_out_valid", out_valid, 0);
            check("fill_sp_wen",    sp_wen, in_valid);
            if (in_valid) begin
                check("fill_sp_waddr", sp_waddr, writes);
                writes++;
            end
            @(negedge clk);
            cyc++;
        end
        if (writes < n) begin
            check("fill_timeout", writes, n);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_read(input int stall_at);
        int  idx        = 0;
        int  cyc        = 0;
        int  stall_left = 0;
        bit  stalled    = 1'b0;
        int  n          = q_addr.size();
        while (idx < n && cyc < 200) begin
            if (!stalled && idx == stall_at) begin
                stall_left = 3;
                stalled    = 1'b1;
            end
            out_ready = (stall_left == 0);
            #1;
            check("rd_out_valid", out_valid, 1);
            check("rd_sp_raddr",  sp_raddr, q_addr[idx]);
            check("rd_out_data",  out_data, q_data[idx]);
            check("rd_out_last",  out_last, q_last[idx]);
            check("rd_out_final", out_final, q_final[idx]);
            if (stall_left > 0) begin
                stall_left--;
            end else begin
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        if (idx < n) begin
            check("read_timeout", idx, n);
        end
        out_ready = 1'b1;
        #1;
        check("done_pulse",     done, 1);
        check("done_busy",      busy, 0);
        check("done_out_valid", out_valid, 0);
        @(negedge clk);
        #1;
        check("done_clear", done, 0);
        q_addr.delete();
        q_data.delete();
        q_last.delete();
        q_final.delete();
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        cfg_len    = '0;
        cfg_win    = '0;
        cfg_stride = '0;
        in_data    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;

        @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // len=8 win=3 stride=2: data 10,11,12,12,13,14,14,15,16
        do_start(8, 3, 2);
        fill(8, 10, 1'b0);
        push(0, 10, 0, 0); push(1, 11, 0, 0); push(2, 12, 1, 0);
        push(2, 12, 0, 0); push(3, 13, 0, 0); push(4, 14, 1, 0);
        push(4, 14, 0, 0); push(5, 15, 0, 0); push(6, 16, 1, 1);
        run_read(-1);

        // Single full-length window
        do_start(4, 4, 1);
        fill(4, 20, 1'b0);
        push(0, 20, 0, 0); push(1, 21, 0, 0); push(2, 22, 0, 0); push(3, 23, 1, 1);
        run_read(-1);

        bad_start("bad_win", 4, 5, 1);
        bad_start("bad_stride", 4, 2, 0);

        // Gapped fill, then a 3-cycle stall mid second window
        do_start(6, 3, 3);
        fill(6, 30, 1'b1);
        push(0, 30, 0, 0); push(1, 31, 0, 0); push(2, 32, 1, 0);
        push(3, 33, 0, 0); push(4, 34, 0, 0); push(5, 35, 1, 1);
        run_read(4);
`ifdef SCRATCHPAD_STALL_CNT_EN
        check("stall_cnt", stall_cnt, 3);
`endif

        // Abort during READ, then restart
        do_start(4, 2, 1);
        fill(4, 50, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start(2, 1, 1);
        fill(2, 40, 1'b0);
        push(0, 40, 1, 0); push(1, 41, 1, 1);
        run_read(-1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
